// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle control FSM for the 16-bit CPU
module cpu_ctrl_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int RET_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             mem_ready,
  output logic             ir_en,
  output logic             pc_en,
  output logic             addr_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             rf_we,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired
);

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              retire;
  logic              timeout;

  assign state   = state_q;
  assign timeout = (WAIT_MAX != 0) && (wait_q == WAIT_LIM) && !mem_ready;

  // The wait counter only runs while a request is outstanding, so it is
  // already zero whenever FETCH or MEM is entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (mem_req && !mem_ready) begin
        wait_q <= wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end
      if (retire) begin
        retired <= retired + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    addr_sel = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    alu_op   = 2'b00;
    wb_sel   = 2'b00;
    rf_we    = 1'b0;
    halted   = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        case (opcode)
          3'b101, 3'b110: state_d = S_MEM;
          3'b111:         state_d = S_HALT;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == 3'b110);
        if (mem_ready) begin
          if (opcode == 3'b101) begin
            rf_we  = 1'b1;
            wb_sel = 2'b10;
          end
          retire  = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        if (opcode == 3'b100) begin
          wb_sel = 2'b01;
        end else begin
          alu_op = opcode[1:0];
        end
        retire  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
